// File: rtl/riscv_constants.sv
// Shared encodings for the PC generator: redirect selects and fetch-FSM states.
package riscv_constants;

  // PC_PLUS4 and PC_TARGET keep the encodings of the original single-width PC register.
  typedef enum logic [2:0] {
    PC_PLUS4  = 3'd0,
    PC_TARGET = 3'd1,
    PC_JALR   = 3'd2,
    PC_TRAP   = 3'd3,
    PC_HOLD   = 3'd4
  } pc_sel_e;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } pc_state_e;

  localparam int unsigned PcStepByte = 4;

  function automatic logic is_misaligned(input logic [1:0] lowBits);
    return lowBits != 2'b00;
  endfunction

endpackage

// File: rtl/riscv_pc_next.sv
// Combinational next-PC select for the RUN state of riscv_pc_gen.
// Alignment checking of jump targets exists only when RISCV_PC_MISALIGN_CHECK_EN is defined.
module riscv_pc_next
  import riscv_constants::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned PC_STEP = 4
) (
  input  logic [XLEN-1:0] pc_i,
  input  pc_sel_e         pc_sel_i,
  input  logic [XLEN-1:0] imm_sext_i,
  input  logic [XLEN-1:0] rs1_val_i,
  input  logic [XLEN-1:0] trap_vec_i,
  input  logic            accepted_i,
  output logic [XLEN-1:0] pc_next_o,
  output logic            redirect_o
`ifdef RISCV_PC_MISALIGN_CHECK_EN
  ,
  output logic            misalign_o
`endif
);

  localparam logic [XLEN-1:0] StepInc  = XLEN'(PC_STEP);
  localparam logic [XLEN-1:0] ClearLsb = ~XLEN'(1);

`ifdef RISCV_PC_MISALIGN_CHECK_EN
  // Word-addressed imem has no sub-word alignment to violate.
  localparam bit CheckEn = (PC_STEP == PcStepByte);
`else
  localparam bit CheckEn = 1'b0;
`endif

  logic [XLEN-1:0] branchTarget;
  logic [XLEN-1:0] jalrSum;
  logic [XLEN-1:0] jalrTarget;
  logic            branchMisaligned;
  logic            jalrMisaligned;

  assign branchTarget     = pc_i + imm_sext_i;
  assign jalrSum          = rs1_val_i + imm_sext_i;
  assign jalrTarget       = jalrSum & ClearLsb;
  assign branchMisaligned = CheckEn && is_misaligned(branchTarget[1:0]);
  assign jalrMisaligned   = CheckEn && is_misaligned(jalrTarget[1:0]);

  // A misaligned jump is diverted to the trap vector instead of being loaded.
  always_comb begin
    pc_next_o  = pc_i;
    redirect_o = 1'b0;
    case (pc_sel_i)
      PC_TRAP: begin
        pc_next_o  = trap_vec_i;
        redirect_o = 1'b1;
      end
      PC_JALR: begin
        pc_next_o  = jalrMisaligned ? trap_vec_i : jalrTarget;
        redirect_o = 1'b1;
      end
      PC_TARGET: begin
        pc_next_o  = branchMisaligned ? trap_vec_i : branchTarget;
        redirect_o = 1'b1;
      end
      PC_PLUS4: begin
        if (accepted_i) begin
          pc_next_o = pc_i + StepInc;
        end
      end
      default: begin
        pc_next_o = pc_i;
      end
    endcase
  end

`ifdef RISCV_PC_MISALIGN_CHECK_EN
  assign misalign_o = ((pc_sel_i == PC_JALR) && jalrMisaligned) ||
                      ((pc_sel_i == PC_TARGET) && branchMisaligned);
`endif

endmodule

// File: rtl/riscv_pc_gen.sv
// Program-counter generator with boot cycle, halt/resume and valid/ready fetch handshake.
// Defining RISCV_PC_MISALIGN_CHECK_EN adds the misalign_err_o output and target alignment trap.
module riscv_pc_gen
  import riscv_constants::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     PC_STEP      = 4
) (
  input  logic            clk_i,
  input  logic            x_reset_i,
  input  pc_sel_e         pc_sel_i,
  input  logic [XLEN-1:0] imm_sext_i,
  input  logic [XLEN-1:0] rs1_val_i,
  input  logic [XLEN-1:0] trap_vec_i,
  input  logic            halt_req_i,
  input  logic            resume_i,
  input  logic            pc_ready_i,
  output logic [XLEN-1:0] pc_out_o,
  output logic            pc_valid_o,
  output logic [XLEN-1:0] pc_prev_o,
  output logic            redirect_o
`ifdef RISCV_PC_MISALIGN_CHECK_EN
  ,
  output logic            misalign_err_o
`endif
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pcPrev_q, pcPrev_d;
  logic            valid_q, valid_d;
  logic            redirect_q, redirect_d;
  logic [XLEN-1:0] runPc;
  logic            runRedirect;
  logic            accepted;
`ifdef RISCV_PC_MISALIGN_CHECK_EN
  logic            misalign_q, misalign_d;
  logic            runMisalign;
`endif

  assign accepted = valid_q & pc_ready_i;

  riscv_pc_next #(
    .XLEN    (XLEN),
    .PC_STEP (PC_STEP)
  ) u_pc_next (
    .pc_i       (pc_q),
    .pc_sel_i   (pc_sel_i),
    .imm_sext_i (imm_sext_i),
    .rs1_val_i  (rs1_val_i),
    .trap_vec_i (trap_vec_i),
    .accepted_i (accepted),
    .pc_next_o  (runPc),
    .redirect_o (runRedirect)
`ifdef RISCV_PC_MISALIGN_CHECK_EN
    ,
    .misalign_o (runMisalign)
`endif
  );

  // A redirect taken together with halt_req still lands before the halt; a trap cancels the halt.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pcPrev_d   = pcPrev_q;
    redirect_d = 1'b0;
`ifdef RISCV_PC_MISALIGN_CHECK_EN
    misalign_d = 1'b0;
`endif
    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        pc_d       = runPc;
        redirect_d = runRedirect;
`ifdef RISCV_PC_MISALIGN_CHECK_EN
        misalign_d = runMisalign;
`endif
        if (accepted) begin
          pcPrev_d = pc_q;
        end
        if (halt_req_i && (pc_sel_i != PC_TRAP)) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        if (pc_sel_i == PC_TRAP) begin
          pc_d       = trap_vec_i;
          redirect_d = 1'b1;
          state_d    = RUN;
        end else if (resume_i) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
    valid_d = (state_d == RUN);
  end

  always_ff @(posedge clk_i or posedge x_reset_i) begin
    if (x_reset_i) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      pcPrev_q   <= RESET_VECTOR;
      valid_q    <= 1'b0;
      redirect_q <= 1'b0;
`ifdef RISCV_PC_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pcPrev_q   <= pcPrev_d;
      valid_q    <= valid_d;
      redirect_q <= redirect_d;
`ifdef RISCV_PC_MISALIGN_CHECK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign pc_out_o   = pc_q;
  assign pc_valid_o = valid_q;
  assign pc_prev_o  = pcPrev_q;
  assign redirect_o = redirect_q;
`ifdef RISCV_PC_MISALIGN_CHECK_EN
  assign misalign_err_o = misalign_q;
`endif

endmodule

// File: tb/tb_riscv_pc_gen.sv
// Bench for riscv_pc_gen: byte-stepped DUT driven from a vector table, plus a word-stepped DUT.
// Expected outputs flow through a scoreboard queue; RISCV_PC_MISALIGN_CHECK_EN selects the alignment expectations.
module tb_riscv_pc_gen;
  import riscv_constants::*;

  localparam logic [31:0] ResetVec  = 32'h0000_0100;
  localparam logic [31:0] ResetVec2 = 32'h0000_0010;
`ifdef RISCV_PC_MISALIGN_CHECK_EN
  localparam bit MisEn = 1'b1;
`else
  localparam bit MisEn = 1'b0;
`endif

  typedef struct {
    string       name;
    pc_sel_e     sel;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] trap;
    logic        halt;
    logic        resume;
    logic        ready;
    logic [31:0] expPc;
    logic        expValid;
    logic [31:0] expPrev;
    logic        expRedirect;
    logic        expMis;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] prev;
    logic        redirect;
    logic        mis;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  pc_sel_e     sel;
  logic [31:0] imm, rs1, trap;
  logic        halt, resume, ready;
  logic [31:0] pcOut, pcPrev;
  logic        pcValid, redirect;
  logic        misErr;

  logic        reset2;
  pc_sel_e     sel2;
  logic [31:0] imm2;
  logic        ready2;
  logic [31:0] pcOut2, pcPrev2;
  logic        pcValid2, redirect2;
  logic        misErr2;

  exp_t expQ[$];
  vec_t vecs[$];
  int   testsRun    = 0;
  int   testsFailed = 0;

  always #5 clock = ~clock;

  riscv_pc_gen #(.XLEN(32), .RESET_VECTOR(ResetVec), .PC_STEP(4)) dut (
    .clk_i      (clock),
    .x_reset_i  (reset),
    .pc_sel_i   (sel),
    .imm_sext_i (imm),
    .rs1_val_i  (rs1),
    .trap_vec_i (trap),
    .halt_req_i (halt),
    .resume_i   (resume),
    .pc_ready_i (ready),
    .pc_out_o   (pcOut),
    .pc_valid_o (pcValid),
    .pc_prev_o  (pcPrev),
    .redirect_o (redirect)
`ifdef RISCV_PC_MISALIGN_CHECK_EN
    ,
    .misalign_err_o (misErr)
`endif
  );

  riscv_pc_gen #(.XLEN(32), .RESET_VECTOR(ResetVec2), .PC_STEP(1)) dutWord (
    .clk_i      (clock),
    .x_reset_i  (reset2),
    .pc_sel_i   (sel2),
    .imm_sext_i (imm2),
    .rs1_val_i  (32'h0),
    .trap_vec_i (32'h900),
    .halt_req_i (1'b0),
    .resume_i   (1'b0),
    .pc_ready_i (ready2),
    .pc_out_o   (pcOut2),
    .pc_valid_o (pcValid2),
    .pc_prev_o  (pcPrev2),
    .redirect_o (redirect2)
`ifdef RISCV_PC_MISALIGN_CHECK_EN
    ,
    .misalign_err_o (misErr2)
`endif
  );

`ifndef RISCV_PC_MISALIGN_CHECK_EN
  assign misErr  = 1'b0;
  assign misErr2 = 1'b0;
`endif

  function automatic vec_t mk(input string name, input pc_sel_e s, input logic [31:0] im,
                              input logic [31:0] r1, input logic [31:0] tv, input logic h,
                              input logic rs, input logic rd, input logic [31:0] ePc,
                              input logic eV, input logic [31:0] ePrev, input logic eR,
                              input logic eM);
    vec_t v;
    v.name = name; v.sel = s; v.imm = im; v.rs1 = r1; v.trap = tv;
    v.halt = h; v.resume = rs; v.ready = rd;
    v.expPc = ePc; v.expValid = eV; v.expPrev = ePrev; v.expRedirect = eR; v.expMis = eM;
    return v;
  endfunction

  task automatic pushExpect(input string name, input logic [31:0] p, input logic v,
                            input logic [31:0] pr, input logic r, input logic m);
    exp_t e;
    e.name = name; e.pc = p; e.valid = v; e.prev = pr; e.redirect = r; e.mis = m;
    expQ.push_back(e);
  endtask

  task automatic checkField(input string name, input string field,
                            input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s.%s: got 0x%08h, expected 0x%08h", name, field, act, exp);
    end
  endtask

  task automatic checkOutput(input bit wordDut);
    exp_t e;
    if (expQ.size() == 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
      return;
    end
    e = expQ.pop_front();
    if (wordDut) begin
      checkField(e.name, "pc_out",   pcOut2,           e.pc);
      checkField(e.name, "pc_valid", {31'b0, pcValid2},  {31'b0, e.valid});
      checkField(e.name, "pc_prev",  pcPrev2,          e.prev);
      checkField(e.name, "redirect", {31'b0, redirect2}, {31'b0, e.redirect});
      if (MisEn) checkField(e.name, "misalign_err", {31'b0, misErr2}, {31'b0, e.mis});
    end else begin
      checkField(e.name, "pc_out",   pcOut,            e.pc);
      checkField(e.name, "pc_valid", {31'b0, pcValid},  {31'b0, e.valid});
      checkField(e.name, "pc_prev",  pcPrev,           e.prev);
      checkField(e.name, "redirect", {31'b0, redirect}, {31'b0, e.redirect});
      if (MisEn) checkField(e.name, "misalign_err", {31'b0, misErr}, {31'b0, e.mis});
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    sel = v.sel; imm = v.imm; rs1 = v.rs1; trap = v.trap;
    halt = v.halt; resume = v.resume; ready = v.ready;
    pushExpect(v.name, v.expPc, v.expValid, v.expPrev, v.expRedirect, v.expMis);
    @(posedge clock);
    #1;
    checkOutput(1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs.push_back(mk("boot_exit",   PC_PLUS4,  32'h0,        32'h0,    32'h0,   0, 0, 1, 32'h100,  1, 32'h100, 0, 0));
    vecs.push_back(mk("plus4_acc",   PC_PLUS4,  32'h0,        32'h0,    32'h0,   0, 0, 1, 32'h104,  1, 32'h100, 0, 0));
    vecs.push_back(mk("plus4_stall", PC_PLUS4,  32'h0,        32'h0,    32'h0,   0, 0, 0, 32'h104,  1, 32'h100, 0, 0));
    vecs.push_back(mk("plus4_acc2",  PC_PLUS4,  32'h0,        32'h0,    32'h0,   0, 0, 1, 32'h108,  1, 32'h104, 0, 0));
    vecs.push_back(mk("hold_acc",    PC_HOLD,   32'h0,        32'h0,    32'h0,   0, 0, 1, 32'h108,  1, 32'h108, 0, 0));
    vecs.push_back(mk("to_200",      PC_TARGET, 32'hF8,       32'h0,    32'h0,   0, 0, 0, 32'h200,  1, 32'h108, 1, 0));
    vecs.push_back(mk("target_neg",  PC_TARGET, 32'hFFFFFFF8, 32'h0,    32'h0,   0, 0, 0, 32'h1F8,  1, 32'h108, 1, 0));
    vecs.push_back(mk("jalr",        PC_JALR,   32'h4,        32'h1001, 32'h0,   0, 0, 1, 32'h1004, 1, 32'h1F8, 1, 0));
    vecs.push_back(mk("hold",        PC_HOLD,   32'h0,        32'h0,    32'h0,   0, 0, 0, 32'h1004, 1, 32'h1F8, 0, 0));
    vecs.push_back(mk("trap_halt",   PC_TRAP,   32'h0,        32'h0,    32'h80,  1, 0, 0, 32'h80,   1, 32'h1F8, 1, 0));
    vecs.push_back(mk("halt_enter",  PC_HOLD,   32'h0,        32'h0,    32'h80,  1, 0, 0, 32'h80,   0, 32'h1F8, 0, 0));
    vecs.push_back(mk("halt_plus4",  PC_PLUS4,  32'h0,        32'h0,    32'h80,  0, 0, 1, 32'h80,   0, 32'h1F8, 0, 0));
    vecs.push_back(mk("halt_target", PC_TARGET, 32'h40,       32'h0,    32'h80,  0, 0, 1, 32'h80,   0, 32'h1F8, 0, 0));
    vecs.push_back(mk("resume",      PC_HOLD,   32'h0,        32'h0,    32'h80,  0, 1, 0, 32'h80,   1, 32'h1F8, 0, 0));
    vecs.push_back(mk("plus4_resum", PC_PLUS4,  32'h0,        32'h0,    32'h80,  0, 0, 1, 32'h84,   1, 32'h80,  0, 0));
    vecs.push_back(mk("to_top",      PC_TARGET, 32'hFFFFFF78, 32'h0,    32'h80,  0, 0, 0, 32'hFFFFFFFC, 1, 32'h80, 1, 0));
    vecs.push_back(mk("wrap",        PC_PLUS4,  32'h0,        32'h0,    32'h80,  0, 0, 1, 32'h0,    1, 32'hFFFFFFFC, 0, 0));
    vecs.push_back(mk("halt2",       PC_HOLD,   32'h0,        32'h0,    32'h80,  1, 0, 0, 32'h0,    0, 32'hFFFFFFFC, 0, 0));
    vecs.push_back(mk("halted_trap", PC_TRAP,   32'h0,        32'h0,    32'h300, 1, 0, 0, 32'h300,  1, 32'hFFFFFFFC, 1, 0));
    vecs.push_back(mk("jalr_halt",   PC_JALR,   32'h10,       32'h400,  32'h300, 1, 0, 1, 32'h410,  0, 32'h300, 1, 0));
    vecs.push_back(mk("resume2",     PC_HOLD,   32'h0,        32'h0,    32'h300, 0, 1, 0, 32'h410,  1, 32'h300, 0, 0));
    vecs.push_back(mk("target_mis",  PC_TARGET, 32'h2,        32'h0,    32'h500, 0, 0, 0,
                      MisEn ? 32'h500 : 32'h412, 1, 32'h300, 1, MisEn));
    vecs.push_back(mk("after_mis",   PC_HOLD,   32'h0,        32'h0,    32'h500, 0, 0, 0,
                      MisEn ? 32'h500 : 32'h412, 1, 32'h300, 0, 0));
    vecs.push_back(mk("jalr_mis",    PC_JALR,   32'h0,        32'h603,  32'h540, 0, 0, 0,
                      MisEn ? 32'h540 : 32'h602, 1, 32'h300, 1, MisEn));
    vecs.push_back(mk("halt3",       PC_HOLD,   32'h0,        32'h0,    32'h540, 1, 0, 0,
                      MisEn ? 32'h540 : 32'h602, 0, 32'h300, 0, 0));

    reset = 1'b1; reset2 = 1'b1;
    sel = PC_HOLD; imm = '0; rs1 = '0; trap = '0; halt = 0; resume = 0; ready = 0;
    sel2 = PC_PLUS4; imm2 = '0; ready2 = 0;
    #12;
    pushExpect("reset", ResetVec, 0, ResetVec, 0, 0);
    checkOutput(1'b0);
    pushExpect("reset_word", ResetVec2, 0, ResetVec2, 0, 0);
    checkOutput(1'b1);

    @(posedge clock);
    #1;
    reset = 1'b0; reset2 = 1'b0;
    pushExpect("boot_cycle", ResetVec, 0, ResetVec, 0, 0);
    checkOutput(1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
    end

    // Word-stepped DUT has been sitting at its reset vector since the boot edge.
    pushExpect("word_idle", ResetVec2, 1, ResetVec2, 0, 0);
    checkOutput(1'b1);
    ready2 = 1'b1;
    pushExpect("word_step", 32'h11, 1, 32'h10, 0, 0);
    @(posedge clock);
    #1;
    checkOutput(1'b1);
    sel2 = PC_TARGET; imm2 = 32'h1;
    pushExpect("word_target_odd", 32'h12, 1, 32'h11, 1, 0);
    @(posedge clock);
    #1;
    checkOutput(1'b1);
    sel2 = PC_HOLD; ready2 = 1'b0;

    // Asynchronous reset arriving mid-cycle while the main DUT is halted.
    #2;
    reset = 1'b1;
    #1;
    pushExpect("reset_halted", ResetVec, 0, ResetVec, 0, 0);
    checkOutput(1'b0);
    sel = PC_TRAP; trap = 32'h700; halt = 0; ready = 1;
    pushExpect("reset_held", ResetVec, 0, ResetVec, 0, 0);
    @(posedge clock);
    #1;
    checkOutput(1'b0);
    reset = 1'b0;
    sel = PC_HOLD;
    pushExpect("reboot_cycle", ResetVec, 0, ResetVec, 0, 0);
    checkOutput(1'b0);
    pushExpect("reboot_run", ResetVec, 1, ResetVec, 0, 0);
    @(posedge clock);
    #1;
    checkOutput(1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
